icache_2way: RTL and testbench
==============================

// Module: icache_2way
// PURPOSE
//  Instruction cache answering pre-IF fetch requests (inst_valid/index/tag/offset, icache_busy).
//  2-way set-associative, 256 sets x 16-byte lines, read-only, no dirty state.
//  Hits return a word one cycle after acceptance. Misses fetch the whole line through a
//  burst read port to the AXI bridge.
//  Sits between the pre-IF/IF stages and the cache-AXI bridge.
// PARAMETERS
//  INDEX_W   8   set index width (2^INDEX_W sets)
//  OFFSET_W  4   byte offset width; words per line WPL = 2^(OFFSET_W-2) = 4
//  TAG_W     20  physical tag width (PFN from ITLB)
// PORTS
//  clk           in   1        clock
//  reset         in   1        synchronous, active-high reset
//  inst_valid    in   1        fetch request valid
//  inst_index    in   INDEX_W  set index (pc[11:4])
//  inst_tag      in   TAG_W    physical tag (ITLB PFN)
//  inst_offset   in   OFFSET_W byte offset in line; [3:2] selects the word
//  inst_cancel   in   1        flush: discard the in-flight (already accepted) request
//  icache_busy   out  1        1 = no request accepted this cycle
//  inst_data_ok  out  1        1-cycle pulse: inst_rdata valid
//  inst_rdata    out  32       instruction word; 0 when inst_data_ok=0
//  rd_req        out  1        line-read request to bridge; held until rd_rdy
//  rd_addr       out  32       {tag,index,4'b0}; stable while rd_req=1
//  rd_rdy        in   1        bridge accepts rd_req this cycle
//  ret_valid     in   1        refill beat valid
//  ret_last      in   1        final refill beat
//  ret_data      in   32       refill data, word 0 first
// BEHAVIOUR
//  - Reset: state IDLE; all valid bits and LRU bits 0; icache_busy=0, inst_data_ok=0,
//    rd_req=0, rd_addr=0. Reset mid-refill aborts to IDLE; the bridge is reset on the same edge.
//  - Accept: inst_valid & ~icache_busy at a posedge latches {index,tag,offset} into the
//    request buffer, clears the cancel flag, and moves to LOOKUP.
//  - IDLE: busy=0.
//  - LOOKUP: tags and valid bits of both ways are compared against the buffered tag.
//    * Hit: data_ok=1 and rdata = hit way word[offset[3:2]] (combinational).
//      lru[index] <= ~hit_way. busy=0, so back-to-back acceptance is allowed.
//      Next state: LOOKUP if a new request is accepted, else IDLE.
//    * Miss: busy=1, data_ok=0. Victim = first invalid way (way0 before way1), else lru[index].
//      Next state: MISS.
//    * Both ways match (illegal): way0 is used.
//  - MISS: rd_req=1, busy=1. On rd_rdy, clear beat counter cnt and move to REFILL.
//  - REFILL: busy=1. Each ret_valid writes ret_data into victim word cnt, then cnt++ (wraps mod WPL).
//    The beat with cnt==offset[3:2] is captured into the rdata register.
//    On ret_valid&ret_last: write tag, set valid, lru[index] <= ~victim, move to RESPOND.
//    ret_last with cnt != WPL-1 still terminates the refill.
//  - RESPOND: data_ok = ~cancelled, rdata = captured word; busy=1; next state IDLE.
//  - Cancel:
//    * inst_cancel in LOOKUP on a hit: data_ok forced 0.
//    * inst_cancel in LOOKUP on a miss: go to IDLE; no refill is issued.
//    * inst_cancel in MISS/REFILL/RESPOND: sets the cancelled flag. The refill still
//      completes and installs the line; data_ok is suppressed.
//    * Cancel never affects a request accepted on the same edge.
//  - Exactly one refill is outstanding at a time. rd_req is never deasserted before rd_rdy.
//  - Latency:
//    * hit: data_ok on the cycle after acceptance.
//    * miss: data_ok on the cycle after ret_last.
// STRUCTURE
//  - Shared header global_defines.vh: ICACHE_INDEX_W, ICACHE_OFFSET_W, ICACHE_TAG_W,
//    state encodings IC_IDLE/IC_LOOKUP/IC_MISS/IC_REFILL/IC_RESPOND.
//  - Sub-module icache_way, instantiated x2, holds:
//    * tag, valid and 4-word data register arrays;
//    * synchronous write;
//    * combinational read of tag/valid/word;
//    * synchronous clear of all valid bits on reset.
//  - The top level holds the FSM, request buffer, LRU bit array, beat counter,
//    captured-word register and cancel flag.
// TESTING
//  1. After reset, request idx=0x10 tag=0x1FC00 off=0x4 -> LOOKUP miss, busy=1;
//     rd_req with rd_addr=0x1FC00100 until rd_rdy.
//     Return beats 0xA0,0xA1,0xA2,0xA3 -> one-cycle data_ok with rdata=0xA1.
//  2. Repeat test 1's address with off=0xC -> data_ok the next cycle, rdata=0xA3, no rd_req.
//     Issue 3 back-to-back requests -> 3 consecutive data_ok pulses.
//  3. Same idx=0x10, tags 0x1, 0x2, 0x3 in sequence -> 0x1 fills way0, 0x2 fills way1,
//     0x3 evicts way0 (LRU). A following 0x2 request hits; a 0x1 request misses.
//  4. Miss, then inst_cancel during REFILL -> line installed, data_ok stays 0.
//     Same address again -> hit.
//  5. inst_cancel in a LOOKUP miss cycle -> no rd_req; state IDLE; busy=0 next cycle.
//  6. Assert reset while in REFILL at cnt=2 -> IDLE, busy=0, rd_req=0.
//     Prior hit address now misses because valid bits were cleared.

Source files
------------

// File: rtl/icache_2way_pkg.sv
// ----------------------------------------------------------------------------
// icache_2way_pkg : shared geometry and FSM encoding for the 2-way I-cache
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package icache_2way_pkg;

  localparam int ICACHE_INDEX_W  = 8;
  localparam int ICACHE_OFFSET_W = 4;
  localparam int ICACHE_TAG_W    = 20;

  typedef enum logic [2:0] {
    IC_IDLE    = 3'd0,
    IC_LOOKUP  = 3'd1,
    IC_MISS    = 3'd2,
    IC_REFILL  = 3'd3,
    IC_RESPOND = 3'd4
  } ic_state_e;

endpackage

`default_nettype wire

// File: rtl/icache_2way_way.sv
// ----------------------------------------------------------------------------
// icache_way : one way of tag/valid/data storage, async read, sync write
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module icache_way
  import icache_2way_pkg::*;
#(
  parameter int INDEX_W = ICACHE_INDEX_W,
  parameter int TAG_W   = ICACHE_TAG_W,
  parameter int WORD_W  = ICACHE_OFFSET_W - 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] index,
  input  logic [WORD_W-1:0]  word_sel,
  output logic [TAG_W-1:0]   tag,
  output logic               valid,
  output logic [31:0]        word,
  input  logic               wr_data_en,
  input  logic [WORD_W-1:0]  wr_word,
  input  logic [31:0]        wr_data,
  input  logic               wr_tag_en,
  input  logic [TAG_W-1:0]   wr_tag
);

  localparam int SETS = 1 << INDEX_W;
  localparam int WPL  = 1 << WORD_W;

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS*WPL];

  // Only valid bits are reset; tag/data contents are don't-care until valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (wr_tag_en) begin
      valid_q[index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_tag_en) begin
      tag_q[index] <= wr_tag;
    end
    if (wr_data_en) begin
      data_q[{index, wr_word}] <= wr_data;
    end
  end

  assign tag   = tag_q[index];
  assign valid = valid_q[index];
  assign word  = data_q[{index, word_sel}];

endmodule

`default_nettype wire

// File: rtl/icache_2way.sv
// ----------------------------------------------------------------------------
// icache_2way : 2-way set-associative read-only instruction cache with refill
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module icache_2way
  import icache_2way_pkg::*;
#(
  parameter int INDEX_W  = ICACHE_INDEX_W,
  parameter int OFFSET_W = ICACHE_OFFSET_W,
  parameter int TAG_W    = ICACHE_TAG_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_valid,
  input  logic [INDEX_W-1:0]  inst_index,
  input  logic [TAG_W-1:0]    inst_tag,
  input  logic [OFFSET_W-1:0] inst_offset,
  input  logic                inst_cancel,
  output logic                icache_busy,
  output logic                inst_data_ok,
  output logic [31:0]         inst_rdata,
  output logic                rd_req,
  output logic [31:0]         rd_addr,
  input  logic                rd_rdy,
  input  logic                ret_valid,
  input  logic                ret_last,
  input  logic [31:0]         ret_data
);

  localparam int WORD_W = OFFSET_W - 2;

  ic_state_e             state, state_nxt;
  logic [INDEX_W-1:0]    req_index;
  logic [TAG_W-1:0]      req_tag;
  logic [WORD_W-1:0]     req_word;
  logic                  cancelled;
  logic                  victim;
  logic [WORD_W-1:0]     cnt;
  logic [31:0]           rdata_q;
  logic [(1<<INDEX_W)-1:0] lru;

  logic [1:0]            way_valid, way_hit, way_wr_data, way_wr_tag;
  logic [TAG_W-1:0]      way_tag  [2];
  logic [31:0]           way_word [2];

  logic                  hit, hit_way, lookup_victim, beat, accept;
  logic [31:0]           rdata_sel;
  logic                  unused_offset_bits;

  assign unused_offset_bits = ^inst_offset[1:0];

  generate
    for (genvar w = 0; w < 2; w++) begin : g_way
      icache_way #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .WORD_W  (WORD_W)
      ) u_way (
        .clk        (clk),
        .reset      (reset),
        .index      (req_index),
        .word_sel   (req_word),
        .tag        (way_tag[w]),
        .valid      (way_valid[w]),
        .word       (way_word[w]),
        .wr_data_en (way_wr_data[w]),
        .wr_word    (cnt),
        .wr_data    (ret_data),
        .wr_tag_en  (way_wr_tag[w]),
        .wr_tag     (req_tag)
      );
      assign way_hit[w] = way_valid[w] && (way_tag[w] == req_tag);
    end
  endgenerate

  // A double match is illegal; way0 wins.
  assign hit           = |way_hit;
  assign hit_way       = ~way_hit[0];
  assign lookup_victim = ~way_valid[0] ? 1'b0 : (~way_valid[1] ? 1'b1 : lru[req_index]);
  assign beat          = (state == IC_REFILL) && ret_valid;
  assign way_wr_data   = {beat & victim, beat & ~victim};
  assign way_wr_tag    = way_wr_data & {2{ret_last}};

  assign icache_busy = (state == IC_LOOKUP) ? ~hit : (state != IC_IDLE);
  assign accept      = inst_valid && !icache_busy;
  assign rd_addr     = rd_req ? {req_tag, req_index, {OFFSET_W{1'b0}}} : 32'd0;
  assign inst_rdata  = inst_data_ok ? rdata_sel : 32'd0;

  always_comb begin
    state_nxt    = state;
    inst_data_ok = 1'b0;
    rdata_sel    = 32'd0;
    rd_req       = 1'b0;
    case (state)
      IC_IDLE: begin
        if (accept) state_nxt = IC_LOOKUP;
      end
      IC_LOOKUP: begin
        if (hit) begin
          inst_data_ok = ~inst_cancel;
          rdata_sel    = hit_way ? way_word[1] : way_word[0];
          state_nxt    = accept ? IC_LOOKUP : IC_IDLE;
        end else begin
          state_nxt = inst_cancel ? IC_IDLE : IC_MISS;
        end
      end
      IC_MISS: begin
        rd_req = 1'b1;
        if (rd_rdy) state_nxt = IC_REFILL;
      end
      IC_REFILL: begin
        if (ret_valid && ret_last) state_nxt = IC_RESPOND;
      end
      IC_RESPOND: begin
        inst_data_ok = ~(cancelled | inst_cancel);
        rdata_sel    = rdata_q;
        state_nxt    = IC_IDLE;
      end
      default: state_nxt = IC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IC_IDLE;
      req_index <= '0;
      req_tag   <= '0;
      req_word  <= '0;
      cancelled <= 1'b0;
      victim    <= 1'b0;
      cnt       <= '0;
      rdata_q   <= 32'd0;
      lru       <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_index <= inst_index;
        req_tag   <= inst_tag;
        req_word  <= inst_offset[OFFSET_W-1:2];
        cancelled <= 1'b0;
      end else if (inst_cancel && (state == IC_MISS || state == IC_REFILL || state == IC_RESPOND)) begin
        cancelled <= 1'b1;
      end
      if (state == IC_LOOKUP) begin
        if (hit) lru[req_index] <= ~hit_way;
        else     victim         <= lookup_victim;
      end
      if (state == IC_MISS && rd_rdy) cnt <= '0;
      if (beat) begin
        cnt <= cnt + WORD_W'(1);
        if (cnt == req_word) rdata_q <= ret_data;
        if (ret_last) lru[req_index] <= ~victim;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icache_2way.sv
// ----------------------------------------------------------------------------
// tb_icache_2way : directed self-checking bench for icache_2way
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_icache_2way;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_valid = 1'b0;
  logic [7:0]  inst_index = '0;
  logic [19:0] inst_tag = '0;
  logic [3:0]  inst_offset = '0;
  logic        inst_cancel = 1'b0;
  logic        icache_busy;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_rdy = 1'b0;
  logic        ret_valid = 1'b0;
  logic        ret_last = 1'b0;
  logic [31:0] ret_data = '0;

  int checks = 0;
  int errors = 0;

  icache_2way dut (
    .clk          (clk),
    .reset        (reset),
    .inst_valid   (inst_valid),
    .inst_index   (inst_index),
    .inst_tag     (inst_tag),
    .inst_offset  (inst_offset),
    .inst_cancel  (inst_cancel),
    .icache_busy  (icache_busy),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_rdy       (rd_rdy),
    .ret_valid    (ret_valid),
    .ret_last     (ret_last),
    .ret_data     (ret_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request from an accepting state; returns in the LOOKUP cycle.
  task automatic req(input logic [7:0] idx, input logic [19:0] tg, input logic [3:0] off);
    inst_valid  = 1'b1;
    inst_index  = idx;
    inst_tag    = tg;
    inst_offset = off;
    #1;
    chk("accept_busy", {31'd0, icache_busy}, 32'd0);
    tick();
    inst_valid = 1'b0;
    #1;
  endtask

  // Entered in a LOOKUP miss cycle; runs MISS, a 4-beat REFILL and RESPOND.
  task automatic refill(input logic [31:0] addr, input logic [31:0] base, input int want,
                        input int cancel_beat, input logic exp_ok);
    tick();
    chk("miss_rd_req", {31'd0, rd_req}, 32'd1);
    chk("miss_rd_addr", rd_addr, addr);
    tick();
    chk("hold_rd_req", {31'd0, rd_req}, 32'd1);
    chk("hold_rd_addr", rd_addr, addr);
    rd_rdy = 1'b1;
    tick();
    rd_rdy = 1'b0;
    #1;
    chk("refill_rd_req", {31'd0, rd_req}, 32'd0);
    chk("refill_busy", {31'd0, icache_busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      ret_valid   = 1'b1;
      ret_data    = base + 32'(i);
      ret_last    = (i == 3);
      inst_cancel = (i == cancel_beat);
      tick();
    end
    ret_valid   = 1'b0;
    ret_last    = 1'b0;
    inst_cancel = 1'b0;
    #1;
    chk("respond_ok", {31'd0, inst_data_ok}, {31'd0, exp_ok});
    chk("respond_rdata", inst_rdata, exp_ok ? base + 32'(want) : 32'd0);
    chk("respond_busy", {31'd0, icache_busy}, 32'd1);
    tick();
    chk("after_respond_ok", {31'd0, inst_data_ok}, 32'd0);
  endtask

  initial begin
    // reset state
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_busy", {31'd0, icache_busy}, 32'd0);
    chk("rst_ok", {31'd0, inst_data_ok}, 32'd0);
    chk("rst_rd_req", {31'd0, rd_req}, 32'd0);
    chk("rst_rd_addr", rd_addr, 32'd0);

    // 1: cold miss and refill, critical word 1
    req(8'h10, 20'h1FC00, 4'h4);
    chk("t1_miss_busy", {31'd0, icache_busy}, 32'd1);
    chk("t1_miss_ok", {31'd0, inst_data_ok}, 32'd0);
    refill(32'h1FC0_0100, 32'hA0, 1, -1, 1'b1);

    // 2: hit, then three back-to-back hits
    req(8'h10, 20'h1FC00, 4'hC);
    chk("t2_hit_ok", {31'd0, inst_data_ok}, 32'd1);
    chk("t2_hit_rdata", inst_rdata, 32'hA3);
    chk("t2_hit_busy", {31'd0, icache_busy}, 32'd0);
    chk("t2_hit_rd_req", {31'd0, rd_req}, 32'd0);
    tick();
    chk("t2_idle_ok", {31'd0, inst_data_ok}, 32'd0);
    inst_valid  = 1'b1;
    inst_offset = 4'h0;
    tick();
    inst_offset = 4'h4;
    #1;
    chk("t2_b2b0", inst_rdata, 32'hA0);
    chk("t2_b2b0_ok", {31'd0, inst_data_ok}, 32'd1);
    tick();
    inst_offset = 4'h8;
    #1;
    chk("t2_b2b1", inst_rdata, 32'hA1);
    tick();
    inst_valid = 1'b0;
    #1;
    chk("t2_b2b2", inst_rdata, 32'hA2);
    chk("t2_b2b2_ok", {31'd0, inst_data_ok}, 32'd1);
    tick();
    chk("t2_end_ok", {31'd0, inst_data_ok}, 32'd0);

    // 3: replacement on a fresh cache
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    req(8'h10, 20'h1, 4'h0);
    chk("t3_miss1", {31'd0, icache_busy}, 32'd1);
    refill(32'h0000_1100, 32'h100, 0, -1, 1'b1);
    req(8'h10, 20'h2, 4'h0);
    chk("t3_miss2", {31'd0, icache_busy}, 32'd1);
    refill(32'h0000_2100, 32'h200, 0, -1, 1'b1);
    req(8'h10, 20'h3, 4'h0);
    chk("t3_miss3", {31'd0, icache_busy}, 32'd1);
    refill(32'h0000_3100, 32'h300, 0, -1, 1'b1);
    req(8'h10, 20'h2, 4'h0);
    chk("t3_hit2_ok", {31'd0, inst_data_ok}, 32'd1);
    chk("t3_hit2_rdata", inst_rdata, 32'h200);
    tick();
    req(8'h10, 20'h1, 4'h0);
    chk("t3_miss1_again", {31'd0, icache_busy}, 32'd1);
    chk("t3_miss1_again_ok", {31'd0, inst_data_ok}, 32'd0);
    refill(32'h0000_1100, 32'h110, 0, -1, 1'b1);

    // 5: tag 0x3 was evicted by the refill above; cancel its lookup miss
    req(8'h10, 20'h3, 4'h0);
    inst_cancel = 1'b1;
    #1;
    chk("t5_miss_busy", {31'd0, icache_busy}, 32'd1);
    chk("t5_miss_ok", {31'd0, inst_data_ok}, 32'd0);
    tick();
    inst_cancel = 1'b0;
    #1;
    chk("t5_idle_busy", {31'd0, icache_busy}, 32'd0);
    chk("t5_no_rd_req", {31'd0, rd_req}, 32'd0);
    tick();
    chk("t5_no_rd_req2", {31'd0, rd_req}, 32'd0);
    req(8'h10, 20'h2, 4'h4);
    chk("t3_hit2_still", inst_rdata, 32'h201);
    tick();

    // 4: cancel during refill installs the line silently
    req(8'h30, 20'hABCDE, 4'h8);
    chk("t4_miss", {31'd0, icache_busy}, 32'd1);
    refill(32'hABCD_E300, 32'hC0, 2, 1, 1'b0);
    req(8'h30, 20'hABCDE, 4'h8);
    chk("t4_hit_ok", {31'd0, inst_data_ok}, 32'd1);
    chk("t4_hit_rdata", inst_rdata, 32'hC2);
    tick();

    // 6: reset in the middle of a refill
    req(8'h40, 20'h5, 4'h0);
    tick();
    rd_rdy = 1'b1;
    tick();
    rd_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ret_valid = 1'b1;
      ret_data  = 32'hE0 + 32'(i);
      tick();
    end
    ret_valid = 1'b0;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("t6_busy", {31'd0, icache_busy}, 32'd0);
    chk("t6_rd_req", {31'd0, rd_req}, 32'd0);
    chk("t6_ok", {31'd0, inst_data_ok}, 32'd0);
    req(8'h30, 20'hABCDE, 4'h8);
    chk("t6_prior_hit_misses", {31'd0, icache_busy}, 32'd1);
    chk("t6_prior_hit_ok", {31'd0, inst_data_ok}, 32'd0);
    inst_cancel = 1'b1;
    tick();
    inst_cancel = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
